instr_fetch_unit: RTL and testbench

//  Upstream stage of control_unit. Owns PC, IR and a hardware return-address stack (RAS).

---
 rtl/instr_fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC, IR and a return-address stack (RAS).
// It fetches instruction words over an IMEM req/valid handshake and applies
// PC commands (increment, jump, call, return) from the control unit.
// Optional feature macro: IFU_STACK_CHECK_EN. When it is defined, a push on a
// full stack is dropped and a pop on an empty stack is refused. Each case sets
// a sticky flag. Without the macro the stack overwrites its oldest entry and a
// pop on empty returns 0.
module instr_fetch_unit #(
   parameter int INSTR_W   = 19,
   parameter int OPCODE_W  = 5,
   parameter int ADDR_W    = 14,
   parameter int RAS_DEPTH = 8,
   parameter int RESET_PC  = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         fetch_req_i,
   input  logic                         inc_pc_i,
   input  logic                         load_pc_i,
   input  logic                         push_ra_i,
   input  logic                         pop_ra_i,
   output logic                         imem_req_o,
   output logic [ADDR_W-1:0]            imem_addr_o,
   input  logic [INSTR_W-1:0]           imem_rdata_i,
   input  logic                         imem_valid_i,
   output logic [OPCODE_W-1:0]          opcode_o,
   output logic [ADDR_W-1:0]            operand_o,
   output logic                         ir_valid_o,
   output logic                         busy_o,
   output logic [ADDR_W-1:0]            pc_o,
   output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
   output logic                         stk_ovf_o,
   output logic                         stk_unf_o
);

   localparam int SW = $clog2(RAS_DEPTH);
   localparam int CW = SW + 1;

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic                irv_q, irv_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [SW-1:0]       sp_q, sp_d;      // next free slot; top is sp_q-1
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
   logic                ras_we;
   logic [SW-1:0]       ras_wa;
   logic [SW-1:0]       top_idx;
   logic [ADDR_W-1:0]   ras_top;
   logic                empty, full;
   logic                ovf_q, ovf_d, unf_q, unf_d;

   assign top_idx = sp_q - SW'(1);
   assign ras_top = ras_q[top_idx];
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(RAS_DEPTH));

   // Fetch FSM next state: latch the address at request, capture IR on valid
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      irv_d   = irv_q;
      case (state_q)
         S_IDLE: if (fetch_req_i) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
            irv_d   = 1'b0;
         end
         S_WAIT: if (imem_valid_i) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            ir_d    = imem_rdata_i;
            irv_d   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // PC and RAS next state, priority POP > LOAD > INC, independent of fetch
   always_comb begin
      pc_d   = pc_q;
      sp_d   = sp_q;
      cnt_d  = cnt_q;
      ras_we = 1'b0;
      ras_wa = sp_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      if (pop_ra_i) begin
         if (empty) begin
`ifdef IFU_STACK_CHECK_EN
            unf_d = 1'b1;
`else
            pc_d  = '0;
`endif
            // A push in the same cycle still lands normally on an empty stack
            if (push_ra_i) begin
               ras_we = 1'b1;
               sp_d   = sp_q + SW'(1);
               cnt_d  = CW'(1);
            end
         end else begin
            pc_d = ras_top;
            if (push_ra_i) begin
               // Swap: replace the top with the current PC, depth unchanged
               ras_we = 1'b1;
               ras_wa = top_idx;
            end else begin
               sp_d  = top_idx;
               cnt_d = cnt_q - CW'(1);
            end
         end
      end else begin
         if (push_ra_i) begin
            if (full) begin
`ifdef IFU_STACK_CHECK_EN
               ovf_d  = 1'b1;
`else
               ras_we = 1'b1;   // circular: overwrites the oldest entry
               sp_d   = sp_q + SW'(1);
`endif
            end else begin
               ras_we = 1'b1;
               sp_d   = sp_q + SW'(1);
               cnt_d  = cnt_q + CW'(1);
            end
         end
         if (load_pc_i)     pc_d = ir_q[ADDR_W-1:0];
         else if (inc_pc_i) pc_d = pc_q + ADDR_W'(1);
      end
   end

   // State registers; reset abandons any fetch in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         ir_q    <= '0;
         irv_q   <= 1'b0;
         pc_q    <= ADDR_W'(RESET_PC);
         sp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         irv_q   <= irv_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage; always written with the PC value from before this edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else if (ras_we) begin
         ras_q[ras_wa] <= pc_q;
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign busy_o      = req_q;
   assign ir_valid_o  = irv_q;
   assign opcode_o    = ir_q[INSTR_W-1 -: OPCODE_W];
   assign operand_o   = ir_q[ADDR_W-1:0];
   assign pc_o        = pc_q;
   assign ras_count_o = cnt_q;
`ifdef IFU_STACK_CHECK_EN
   assign stk_ovf_o   = ovf_q;
   assign stk_unf_o   = unf_q;
`else
   assign stk_ovf_o   = 1'b0;
   assign stk_unf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit, expected values hand-computed.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req = 1'b0, inc_pc = 1'b0, load_pc = 1'b0;
   logic        push_ra = 1'b0, pop_ra = 1'b0;
   logic        imem_req, imem_valid = 1'b0;
   logic [13:0] imem_addr, operand, pc;
   logic [18:0] imem_rdata = '0;
   logic [4:0]  opcode;
   logic        ir_valid, busy, stk_ovf, stk_unf;
   logic [3:0]  ras_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk_i(clk), .rst_ni(rst_n),
      .fetch_req_i(fetch_req), .inc_pc_i(inc_pc), .load_pc_i(load_pc),
      .push_ra_i(push_ra), .pop_ra_i(pop_ra),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_rdata_i(imem_rdata), .imem_valid_i(imem_valid),
      .opcode_o(opcode), .operand_o(operand), .ir_valid_o(ir_valid),
      .busy_o(busy), .pc_o(pc), .ras_count_o(ras_count),
      .stk_ovf_o(stk_ovf), .stk_unf_o(stk_unf)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // inputs change 1ns after the rising edge; outputs are read at the same point
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // fetch with minimum latency (valid at the second edge after the request)
   task automatic do_fetch(input logic [18:0] d);
      fetch_req = 1'b1; step(); fetch_req = 1'b0;
      step();
      imem_rdata = d; imem_valid = 1'b1; step(); imem_valid = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_pc", pc, 0);
      chk("rst_irv", ir_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_cnt", ras_count, 0);
      chk("rst_ovf", stk_ovf, 0);
      chk("rst_unf", stk_unf, 0);
      @(posedge clk); #1; rst_n = 1'b1;

      // fetch with valid three cycles after request
      fetch_req = 1'b1; step(); fetch_req = 1'b0;
      chk("f_req", imem_req, 1);
      chk("f_busy", busy, 1);
      chk("f_addr", imem_addr, 0);
      step(); step();
      chk("f_hold_req", imem_req, 1);
      chk("f_hold_addr", imem_addr, 0);
      imem_rdata = 19'h2A005; imem_valid = 1'b1; step(); imem_valid = 1'b0;
      chk("f_irv", ir_valid, 1);
      chk("f_opcode", opcode, 5'h0A);
      chk("f_operand", operand, 14'h2005);   // low 14 bits of 0x2A005
      chk("f_done_busy", busy, 0);
      chk("f_done_req", imem_req, 0);

      // INC_PC wraps all-ones to zero
      do_fetch(19'h03FFF);
      load_pc = 1'b1; step(); load_pc = 1'b0;
      chk("ld_3fff", pc, 14'h3FFF);
      inc_pc = 1'b1; step(); inc_pc = 1'b0;
      chk("inc_wrap", pc, 0);

      // LOAD_PC beats INC_PC
      do_fetch(19'h00123);
      load_pc = 1'b1; inc_pc = 1'b1; step(); load_pc = 1'b0; inc_pc = 1'b0;
      chk("ld_over_inc", pc, 14'h0123);

      // CALL then RET
      do_fetch(19'h0000A);
      load_pc = 1'b1; step(); load_pc = 1'b0;
      chk("pc_10", pc, 10);
      do_fetch(19'h00200);
      push_ra = 1'b1; load_pc = 1'b1; step(); push_ra = 1'b0; load_pc = 1'b0;
      chk("call_pc", pc, 14'h0200);
      chk("call_cnt", ras_count, 1);
      pop_ra = 1'b1; step(); pop_ra = 1'b0;
      chk("ret_pc", pc, 10);
      chk("ret_cnt", ras_count, 0);

      // nine pushes from PC=10: values 10..18 offered, PC ends at 19
      push_ra = 1'b1; inc_pc = 1'b1;
      for (int i = 0; i < 9; i++) step();
      push_ra = 1'b0; inc_pc = 1'b0;
      chk("p9_cnt", ras_count, 8);
      chk("p9_pc", pc, 19);
`ifdef IFU_STACK_CHECK_EN
      chk("p9_ovf", stk_ovf, 1);
      // 10..17 kept, 18 dropped
      for (int i = 0; i < 8; i++) begin
         pop_ra = 1'b1; step(); pop_ra = 1'b0;
         chk("pop_pc", pc, 17 - i);
      end
      pop_ra = 1'b1; step(); pop_ra = 1'b0;
      chk("unf_pc", pc, 10);
      chk("unf_flag", stk_unf, 1);
      chk("unf_cnt", ras_count, 0);
`else
      chk("p9_ovf", stk_ovf, 0);
      // oldest (10) lost, 11..18 remain
      for (int i = 0; i < 8; i++) begin
         pop_ra = 1'b1; step(); pop_ra = 1'b0;
         chk("pop_pc", pc, 18 - i);
      end
      pop_ra = 1'b1; step(); pop_ra = 1'b0;
      chk("unf_pc", pc, 0);
      chk("unf_flag", stk_unf, 0);
      chk("unf_cnt", ras_count, 0);
`endif

      // swap: push X, then push+pop -> PC=X, top=X+1
      do_fetch(19'h00040);
      load_pc = 1'b1; step(); load_pc = 1'b0;
      push_ra = 1'b1; inc_pc = 1'b1; step(); inc_pc = 1'b0;
      chk("sw_push_pc", pc, 14'h41);
      pop_ra = 1'b1; step(); push_ra = 1'b0; pop_ra = 1'b0;
      chk("sw_pc", pc, 14'h40);
      chk("sw_cnt", ras_count, 1);
      pop_ra = 1'b1; step(); pop_ra = 1'b0;
      chk("sw_pop_pc", pc, 14'h41);
      chk("sw_pop_cnt", ras_count, 0);

      // reset in WAIT abandons the fetch; late valid ignored
      fetch_req = 1'b1; step(); fetch_req = 1'b0;
      chk("rw_busy_pre", busy, 1);
      rst_n = 1'b0; #1;
      chk("rw_req", imem_req, 0);
      chk("rw_busy", busy, 0);
      step(); rst_n = 1'b1;
      imem_rdata = 19'h7FFFF; imem_valid = 1'b1; step(); imem_valid = 1'b0;
      chk("rw_irv", ir_valid, 0);
      chk("rw_opcode", opcode, 0);

      // LOAD_PC and FETCH_REQ during WAIT do not disturb the fetch
      inc_pc = 1'b1; step(); step(); step(); inc_pc = 1'b0;
      chk("w_pc3", pc, 3);
      fetch_req = 1'b1; step(); fetch_req = 1'b0;
      chk("w_addr", imem_addr, 3);
      load_pc = 1'b1; step(); load_pc = 1'b0;
      chk("w_ld_pc", pc, 0);
      chk("w_addr_hold", imem_addr, 3);
      fetch_req = 1'b1; step(); fetch_req = 1'b0;
      chk("w_refetch_addr", imem_addr, 3);
      chk("w_refetch_busy", busy, 1);
      imem_rdata = 19'h1C0AB; imem_valid = 1'b1; step(); imem_valid = 1'b0;
      chk("w_irv", ir_valid, 1);
      chk("w_opcode", opcode, 5'h07);
      chk("w_operand", operand, 14'h00AB);
      chk("w_req", imem_req, 0);

      // IMEM_VALID in IDLE is ignored
      imem_rdata = 19'h55555; imem_valid = 1'b1; step(); imem_valid = 1'b0;
      chk("idle_operand", operand, 14'h00AB);
      chk("idle_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
